// File: rtl/digit_bbox_locate_pkg.sv
// Shared definitions for the digit bounding-box locator.
//   - Q10 scan ratio constants (scan line = top + h * NUM / 1024)
//   - default box / scan positions used before the first measured frame
//   - FSM state encoding
package digit_bbox_locate_pkg;

   localparam int SCAN1_NUM = 410;   // ~0.40 of box height
   localparam int SCAN2_NUM = 683;   // ~0.667 of box height

   localparam logic [9:0]  DEF_Y_MIN  = 10'd110;
   localparam logic [9:0]  DEF_Y_MAX  = 10'd610;
   localparam logic [10:0] DEF_X_MIN  = 11'd390;
   localparam logic [10:0] DEF_X_MAX  = 11'd890;
   localparam logic [9:0]  DEF_SCANY1 = 10'd310;
   localparam logic [9:0]  DEF_SCANY2 = 10'd443;
   localparam logic [10:0] DEF_SCANX  = 11'd640;

   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_ACCUM   = 3'd1,
      ST_CALC1   = 3'd2,
      ST_CALC2   = 3'd3,
      ST_PUBLISH = 3'd4
   } bbox_state_t;

endpackage

// File: rtl/digit_bbox_locate_if.sv
// Pixel-stream input and published-box output bundle of digit_bbox_locate.
//   vcnt/hcnt/Bit : raster position and binarised pixel (1 = foreground)
//   y_min..x_max  : bounding box of the last valid frame
//   scany1/scany2 : horizontal scan lines, scanx : vertical scan column
//   box_valid     : last publish passed the size check
//   box_update    : one-cycle pulse when outputs are republished
interface digit_bbox_locate_if;
   logic [9:0]  vcnt;
   logic [10:0] hcnt;
   logic        Bit;
   logic [9:0]  y_min;
   logic [9:0]  y_max;
   logic [10:0] x_min;
   logic [10:0] x_max;
   logic [9:0]  scany1;
   logic [9:0]  scany2;
   logic [10:0] scanx;
   logic        box_valid;
   logic        box_update;

   modport master (
      output vcnt, hcnt, Bit,
      input  y_min, y_max, x_min, x_max, scany1, scany2, scanx, box_valid, box_update
   );

   modport slave (
      input  vcnt, hcnt, Bit,
      output y_min, y_max, x_min, x_max, scany1, scany2, scanx, box_valid, box_update
   );
endinterface

// File: rtl/digit_bbox_locate_run_filter.sv
// Run-length noise filter for the binarised pixel stream.
//   clk, rst_n : clock, async active-low reset
//   vcnt, hcnt : raster position
//   Bit        : binarised pixel
//   qual       : pixel is foreground, in the active area and ends a run of
//                at least MIN_RUN consecutive foreground pixels
//   first      : qual for the first time in the current run
module bbox_run_filter #(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int MIN_RUN  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  vcnt,
   input  logic [10:0] hcnt,
   input  logic        Bit,
   output logic        qual,
   output logic        first
);

   localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
   localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);
   localparam logic [3:0]  RUN_TH = 4'(MIN_RUN - 1);

   logic [3:0] run_q;
   logic [3:0] run_prev;
   logic       in_active;

   // Count of foreground pixels before this one in the same line; the
   // first pixel of a line never inherits the previous line's run.
   assign run_prev  = (hcnt == 11'd0) ? 4'd0 : run_q;
   assign in_active = (hcnt < H_LIM) && (vcnt < V_LIM);
   assign qual      = Bit && in_active && (run_prev >= RUN_TH);
   assign first     = qual && (run_prev == RUN_TH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 4'd0;
      end else if (!Bit) begin
         run_q <= 4'd0;
      end else if (run_prev != 4'hF) begin
         run_q <= run_prev + 4'd1;
      end else begin
         run_q <= 4'hF;
      end
   end

endmodule

// File: rtl/digit_bbox_locate.sv
// Per-frame bounding-box locator ahead of the digit recogniser.
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : pixel stream in, published box / scan positions out
//
// state    | meaning
// ---------|---------------------------------------------------------
// HOLD     | outputs stable, waiting for line 1 to start a frame
// ACCUM    | accumulating extrema of qualified pixels
// CALC1    | box height/width and size check
// CALC2    | scan offsets h*410, h*683 (Q10)
// PUBLISH  | load outputs (if box ok), pulse box_update
module digit_bbox_locate
   import digit_bbox_locate_pkg::*;
#(
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int LATCH_LINE = 800,
   parameter int MIN_RUN    = 4,
   parameter int MIN_W      = 32,
   parameter int MIN_H      = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   digit_bbox_locate_if.slave bus
);

   localparam logic [10:0] RUN_OFS = 11'(MIN_RUN - 1);

   bbox_state_t state_q, state_d;

   logic qual, first;
   logic line1, trig;
   logic acc_clr, acc_en, calc1_en, calc2_en, pub_en;

   logic [10:0] acc_xmin, acc_xmax;
   logic [9:0]  acc_ymin, acc_ymax;
   logic        found;

   logic [9:0]  h_q;
   logic [10:0] w_q;
   logic        ok_q;
   logic [8:0]  ofs1_q;
   logic [9:0]  ofs2_q;

   logic [9:0]  y_min_q, y_max_q, scany1_q, scany2_q;
   logic [10:0] x_min_q, x_max_q, scanx_q;
   logic        valid_q, update_q;

   bbox_run_filter #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .MIN_RUN  (MIN_RUN)
   ) u_run_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .vcnt  (bus.vcnt),
      .hcnt  (bus.hcnt),
      .Bit   (bus.Bit),
      .qual  (qual),
      .first (first)
   );

   assign line1 = (bus.vcnt == 10'd1);
   assign trig  = (bus.vcnt == 10'(LATCH_LINE)) && (bus.hcnt == 11'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_HOLD;
      else        state_q <= state_d;
   end

   // Line 1 outside HOLD means the previous frame never completed: restart.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HOLD:    if (line1) state_d = ST_ACCUM;
         ST_ACCUM:   if (!line1 && trig) state_d = ST_CALC1;
         ST_CALC1:   state_d = line1 ? ST_ACCUM : ST_CALC2;
         ST_CALC2:   state_d = line1 ? ST_ACCUM : ST_PUBLISH;
         ST_PUBLISH: state_d = line1 ? ST_ACCUM : ST_HOLD;
         default:    state_d = ST_HOLD;
      endcase
   end

   always_comb begin
      acc_clr  = line1;
      acc_en   = (state_q == ST_ACCUM)   && !line1;
      calc1_en = (state_q == ST_CALC1)   && !line1;
      calc2_en = (state_q == ST_CALC2)   && !line1;
      pub_en   = (state_q == ST_PUBLISH) && !line1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_xmin <= 11'h7FF;
         acc_xmax <= 11'd0;
         acc_ymin <= 10'h3FF;
         acc_ymax <= 10'd0;
         found    <= 1'b0;
      end else if (acc_clr) begin
         acc_xmin <= 11'h7FF;
         acc_xmax <= 11'd0;
         acc_ymin <= 10'h3FF;
         acc_ymax <= 10'd0;
         found    <= 1'b0;
      end else if (acc_en && qual) begin
         // The run started MIN_RUN-1 pixels before its first qualified pixel.
         if (first && ((bus.hcnt - RUN_OFS) < acc_xmin)) acc_xmin <= bus.hcnt - RUN_OFS;
         if (bus.hcnt > acc_xmax) acc_xmax <= bus.hcnt;
         if (bus.vcnt < acc_ymin) acc_ymin <= bus.vcnt;
         if (bus.vcnt > acc_ymax) acc_ymax <= bus.vcnt;
         found <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q    <= 10'd0;
         w_q    <= 11'd0;
         ok_q   <= 1'b0;
         ofs1_q <= 9'd0;
         ofs2_q <= 10'd0;
      end else begin
         if (calc1_en) begin
            h_q  <= acc_ymax - acc_ymin;
            w_q  <= acc_xmax - acc_xmin;
            ok_q <= found && ((acc_xmax - acc_xmin) >= 11'(MIN_W))
                          && ((acc_ymax - acc_ymin) >= 10'(MIN_H));
         end
         if (calc2_en) begin
            ofs1_q <= 9'((19'(h_q) * 19'(SCAN1_NUM)) >> 10);
            ofs2_q <= 10'((20'(h_q) * 20'(SCAN2_NUM)) >> 10);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_min_q  <= DEF_Y_MIN;
         y_max_q  <= DEF_Y_MAX;
         x_min_q  <= DEF_X_MIN;
         x_max_q  <= DEF_X_MAX;
         scany1_q <= DEF_SCANY1;
         scany2_q <= DEF_SCANY2;
         scanx_q  <= DEF_SCANX;
         valid_q  <= 1'b0;
         update_q <= 1'b0;
      end else begin
         update_q <= pub_en;
         if (pub_en) begin
            valid_q <= ok_q;
            // Offsets are fractions of the box size, so the sums stay in range.
            if (ok_q) begin
               y_min_q  <= acc_ymin;
               y_max_q  <= acc_ymax;
               x_min_q  <= acc_xmin;
               x_max_q  <= acc_xmax;
               scany1_q <= acc_ymin + 10'(ofs1_q);
               scany2_q <= acc_ymin + ofs2_q;
               scanx_q  <= acc_xmin + 11'(w_q[10:1]);
            end
         end
      end
   end

   assign bus.y_min      = y_min_q;
   assign bus.y_max      = y_max_q;
   assign bus.x_min      = x_min_q;
   assign bus.x_max      = x_max_q;
   assign bus.scany1     = scany1_q;
   assign bus.scany2     = scany2_q;
   assign bus.scanx      = scanx_q;
   assign bus.box_valid  = valid_q;
   assign bus.box_update = update_q;

endmodule
